// File: rtl/pwm_peripheral_if.sv
// Register-side and pin-side signals of the PWM peripheral, bundled for port connection.
// The master drives the SPI-written control registers; the slave is the PWM block driving the pins.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        pwm_period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, pwm_period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, pwm_period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// PWM output stage: prescaled 8-bit counter, one shared waveform, per-pin off/static-high/PWM select.
// Define PWM_SHADOW_EN to double-buffer the duty cycle so it only changes at period boundaries.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_peripheral_if.slave bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] prescale_count;
  logic          step;
  logic [7:0]    pwm_counter;
  logic          wrap;
  logic [7:0]    active_duty;
  logic          pwm_level;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;

  assign step   = (prescale_count == PW'(CLK_DIV - 1));
  assign wrap   = step && (pwm_counter == 8'hFF);
  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_count <= '0;
    end else if (step) begin
      prescale_count <= '0;
    end else begin
      prescale_count <= prescale_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_counter      <= 8'h00;
      bus.pwm_period_start <= 1'b0;
    end else begin
      if (step) begin
        pwm_counter <= pwm_counter + 8'h01;
      end
      bus.pwm_period_start <= wrap;
    end
  end

`ifdef PWM_SHADOW_EN
  // Loaded on the wrapping strobe so the new duty is in place on the first cycle of the next period.
  logic [7:0] duty_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= 8'h00;
    end else if (wrap) begin
      duty_shadow <= bus.pwm_duty_cycle;
    end
  end

  assign active_duty = duty_shadow;
`else
  assign active_duty = bus.pwm_duty_cycle;
`endif

  // 0xFF is treated as full-on so the output does not drop for one step at counter 255.
  always_comb begin
    pwm_level = 1'b0;
    if (active_duty == 8'hFF) begin
      pwm_level = 1'b1;
    end else begin
      pwm_level = (pwm_counter < active_duty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out <= 16'h0000;
    end else begin
      bus.out <= en_out & (~en_pwm | {16{pwm_level}});
    end
  end
endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five control registers written over SPI: output enables at 0x00/0x01, PWM-mode enables at 0x02/0x03, and duty cycle at 0x04. Drives the 16 chip outputs.
A prescaled 8-bit counter generates one PWM waveform, about 3 kHz at a 10 MHz clk. Each output bit is forced low, held static high, or driven with that waveform, according to its enable bits.
Sits directly downstream of the SPI peripheral's register bank; outputs go to uo_out/uio_out.

Parameters:
CLK_DIV, 13, clk cycles per PWM counter step (legal range 1..255); PWM period = CLK_DIV*256 clk cycles

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_reg_out_7_0  input  8  output enable, bits 7:0 (reg 0x00)
en_reg_out_15_8  input  8  output enable, bits 15:8 (reg 0x01)
en_reg_pwm_7_0  input  8  PWM-mode select, bits 7:0 (reg 0x02)
en_reg_pwm_15_8  input  8  PWM-mode select, bits 15:8 (reg 0x03)
pwm_duty_cycle  input  8  duty, 0x00 = 0%, 0xFF = 100% (reg 0x04)
out  output  16  registered output pins
pwm_period_start  output  1  one-clk pulse on the first cycle of each PWM period

Behaviour:
- Reset (async, rst_n=0):
  - prescaler count = 0, pwm_counter = 0, active duty = 0x00
  - out = 16'h0000, pwm_period_start = 0
- Prescaler:
  - counts 0..CLK_DIV-1 and wraps to 0.
  - step strobe asserts when count == CLK_DIV-1.
  - CLK_DIV=1 → strobe every cycle.
- pwm_counter: 8-bit; increments on each step strobe; wraps 255→0 with no stall.
- pwm_period_start: registered; 1 for exactly one clk on the cycle after a strobe that wraps 255→0; 0 otherwise.
- PWM level (combinational from current state):
  - active duty == 0xFF → 1 (full on, no glitch at wrap)
  - otherwise → (pwm_counter < active duty), unsigned compare
  - duty 0x00 → constantly 0
- Per bit i (en_out = {en_reg_out_15_8, en_reg_out_7_0}, en_pwm likewise):
  - en_out[i]=0 → out[i] = 0, regardless of en_pwm[i]
  - en_out[i]=1, en_pwm[i]=0 → out[i] = 1
  - en_out[i]=1, en_pwm[i]=1 → out[i] = PWM level
- Latency: out is registered. Values of enables, counter and active duty in cycle n appear on out in cycle n+1.
- Enable changes:
  - take effect at the next clk edge, without waiting for a period boundary.
  - no reset of counters on enable changes.
- High time per period = active duty × CLK_DIV clk cycles (duty ≠ 0xFF). Duty 0xFF → full period.
- Reset mid-period: counters, out and active duty return to reset values immediately. Counting resumes from 0 on the first clk after rst_n rises.

Optional Feature:
Macro PWM_SHADOW_EN.
- Defined:
  - active duty is a shadow register, loaded from pwm_duty_cycle only on the strobe that wraps pwm_counter 255→0. It is therefore valid from the first cycle of the new period.
  - duty writes mid-period do not affect the current period, so there are no runt or extended pulses.
- Undefined:
  - active duty = pwm_duty_cycle directly; changes affect the compare on the next clk.
  - no shadow flops are instantiated.

Test Plan:
- Reset, then en_reg_out_7_0=0x01, all others 0 → out=0x0001 one clk later and held. Same with en_reg_out_15_8=0x80 added → out=0x8001.
- en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80, CLK_DIV=13:
  - every bit high 1664 clk, low 1664 clk, period 3328 clk
  - pwm_period_start pulses every 3328 clk
- duty=0x00 → out=0x0000 for ≥2 periods. duty=0xFF → out=0xFFFF for ≥2 periods, no low cycle at the 255→0 wrap.
- en_out=0x00FF, en_pwm=0xFF00, duty=0x40 → out[15:8]=0 and out[7:0]=0xFF constant. Then set en_out=0xFFFF → out[15:8] toggles with 25% high (832 clk per period).
- PWM_SHADOW_EN defined: duty 0x40→0xC0 at pwm_counter=0x10 → current period keeps 832-clk high time; next period starts at pwm_period_start with 2496-clk high time. Undefined: new compare applies from the next clk.
- Assert rst_n=0 at pwm_counter=0x7F with out=0xFFFF → out=0x0000 immediately; after release, first pwm_period_start occurs exactly 3328 clk later.
